// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator.
//   op_e    : opcodes accepted on the operand field (5-7 are illegal)
//   err_e   : error code returned alongside every result
//   state_e : top-level handshake FSM states
package calc_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        DIV = 3'd3,
        POW = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_DIV0   = 2'd1,
        ERR_NEGEXP = 2'd2,
        ERR_OP     = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_calculator_if.sv
// Request/response bundle of the sequential calculator.
//   in_valid/in_ready  : operand handshake (a, b, operand)
//   out_valid/out_ready: result handshake (result, err)
//   busy               : calculator is in CALC or DONE
// master = requester/consumer side, slave = calculator side.
interface seq_calculator_if #(
    parameter int NB = 40
);
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [2:0]    operand;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] result;
    logic [1:0]    err;
    logic          busy;

    modport master (
        output in_valid, a, b, operand, out_ready,
        input  in_ready, out_valid, result, err, busy
    );

    modport slave (
        input  in_valid, a, b, operand, out_ready,
        output in_ready, out_valid, result, err, busy
    );
endinterface

// File: rtl/calc_divider.sv
// Iterative signed restoring divider, one quotient bit per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor and begin (divisor must be non-zero)
//   dividend  : signed NB-bit dividend
//   divisor   : signed NB-bit divisor
//   done      : high during the last iteration cycle
//   quotient  : signed quotient, truncated toward zero; valid while done=1
// Works on magnitudes; the sign is reapplied at the output. The quotient is
// presented from the final step's combinational value so the caller can
// capture it on the same edge the last iteration completes.
module calc_divider #(
    parameter int NB = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NB-1:0] dividend,
    input  logic [NB-1:0] divisor,
    output logic          done,
    output logic [NB-1:0] quotient
);
    localparam int CW = $clog2(NB + 1);

    logic          running;
    logic [CW-1:0] cnt;
    logic [NB-1:0] rem_q;
    logic [NB-1:0] quo_q;
    logic [NB-1:0] dmag_q;
    logic          neg_q;

    logic [NB:0]   rem_sh;
    logic [NB:0]   diff;
    logic [NB-1:0] rem_nxt;
    logic [NB-1:0] quo_nxt;
    logic [NB-1:0] dividend_mag;
    logic [NB-1:0] divisor_mag;

    // Most-negative magnitude 2^(NB-1) still fits as an unsigned NB-bit value.
    assign dividend_mag = dividend[NB-1] ? ('0 - dividend) : dividend;
    assign divisor_mag  = divisor[NB-1]  ? ('0 - divisor)  : divisor;

    always_comb begin
        rem_sh = {rem_q, quo_q[NB-1]};
        diff   = rem_sh - {1'b0, dmag_q};
        if (diff[NB]) begin
            rem_nxt = rem_sh[NB-1:0];
            quo_nxt = {quo_q[NB-2:0], 1'b0};
        end else begin
            rem_nxt = diff[NB-1:0];
            quo_nxt = {quo_q[NB-2:0], 1'b1};
        end
    end

    assign done     = running && (cnt == CW'(1));
    assign quotient = neg_q ? ('0 - quo_nxt) : quo_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dmag_q  <= '0;
            neg_q   <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CW'(NB);
            rem_q   <= '0;
            quo_q   <= dividend_mag;
            dmag_q  <= divisor_mag;
            neg_q   <= dividend[NB-1] ^ divisor[NB-1];
        end else if (running) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1))
                running <= 1'b0;
        end
    end
endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle handshaked calculator: add, sub, mul, div, pow on signed NB-bit
// operands, results truncated to NB bits.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_calculator_if slave (operand and result handshakes, busy)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for an operand transfer
//   CALC  | divider running, or one square-and-multiply step per cycle
//   DONE  | out_valid=1, result/err held until out_ready
module seq_calculator
    import calc_pkg::*;
#(
    parameter int NB = 40
) (
    input  logic             clk,
    input  logic             rst,
    seq_calculator_if.slave  bus
);
    localparam logic [NB-1:0] ONE = {{(NB-1){1'b0}}, 1'b1};

    state_e        state;
    state_e        state_nxt;
    logic [NB-1:0] result_q;
    err_e          err_q;
    logic          div_mode;
    logic [NB-1:0] acc_q;
    logic [NB-1:0] base_q;
    logic [NB-1:0] exp_q;

    op_e           op_in;
    logic          accept;
    logic          div_start;
    logic          div_done;
    logic [NB-1:0] div_quot;
    logic [NB-1:0] acc_step;
    logic          pow_last;

    assign op_in     = op_e'(bus.operand);
    assign accept    = (state == IDLE) && bus.in_valid;
    assign div_start = accept && (op_in == DIV) && (|bus.b);

    assign acc_step = exp_q[0] ? (acc_q * base_q) : acc_q;
    // Exponent becomes zero after this step: leave CALC.
    assign pow_last = (exp_q[NB-1:1] == '0);

    calc_divider #(.NB(NB)) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (bus.a),
        .divisor  (bus.b),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    case (op_in)
                        DIV:     state_nxt = (|bus.b) ? CALC : DONE;
                        POW:     state_nxt = (!bus.b[NB-1] && (|bus.b)) ? CALC : DONE;
                        default: state_nxt = DONE;
                    endcase
                end
            end
            CALC: begin
                if (div_mode ? div_done : pow_last)
                    state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            CALC:    bus.busy      = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready  = 1'b0;
        endcase
    end

    assign bus.result = result_q;
    assign bus.err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            err_q    <= ERR_NONE;
            div_mode <= 1'b0;
            acc_q    <= '0;
            base_q   <= '0;
            exp_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_mode <= 1'b0;
                        err_q    <= ERR_NONE;
                        case (op_in)
                            ADD: result_q <= bus.a + bus.b;
                            SUB: result_q <= bus.a - bus.b;
                            MUL: result_q <= bus.a * bus.b;
                            DIV: begin
                                div_mode <= 1'b1;
                                result_q <= '0;
                                if (bus.b == '0)
                                    err_q <= ERR_DIV0;
                            end
                            POW: begin
                                if (bus.b[NB-1]) begin
                                    result_q <= '0;
                                    err_q    <= ERR_NEGEXP;
                                end else begin
                                    // b=0 goes straight to DONE with this value.
                                    result_q <= ONE;
                                    acc_q    <= ONE;
                                    base_q   <= bus.a;
                                    exp_q    <= bus.b;
                                end
                            end
                            default: begin
                                result_q <= '0;
                                err_q    <= ERR_OP;
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (div_mode) begin
                        if (div_done)
                            result_q <= div_quot;
                    end else begin
                        acc_q    <= acc_step;
                        base_q   <= base_q * base_q;
                        exp_q    <= exp_q >> 1;
                        result_q <= acc_step;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;
    localparam int NB = 40;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    seq_calculator_if #(.NB(NB)) bus ();

    seq_calculator #(.NB(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [NB-1:0] av, input logic [NB-1:0] bv,
                          input logic [NB-1:0] exp_res, input logic [1:0] exp_err,
                          input int exp_lat);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.operand  = op;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        check({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_released"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_mis = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.operand   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        //      tag          op    a                       b                 result                  err lat
        run_op("add",       3'd0, -5,                     7,                2,                      0,  1);
        run_op("sub",       3'd1, 3,                      10,               -7,                     0,  1);
        run_op("mul_wrap",  3'd2, 40'h7F_FFFF_FFFF,       2,                -2,                     0,  1);
        run_op("div_neg",   3'd3, -7,                     2,                -3,                     0,  41);
        run_op("div_pos",   3'd3, 100,                    7,                14,                     0,  41);
        run_op("div_negb",  3'd3, 7,                      -2,               -3,                     0,  41);
        run_op("div_minm1", 3'd3, 40'h80_0000_0000,       -1,               40'h80_0000_0000,       0,  41);
        run_op("div_zero",  3'd3, 123,                    0,                0,                      1,  1);
        run_op("pow_3_5",   3'd4, 3,                      5,                243,                    0,  4);
        run_op("pow_0_0",   3'd4, 0,                      0,                1,                      0,  1);
        run_op("pow_m2_3",  3'd4, -2,                     3,                -8,                     0,  3);
        run_op("pow_2_40",  3'd4, 2,                      40,               0,                      0,  7);
        run_op("pow_negexp",3'd4, 3,                      -1,               0,                      2,  1);
        run_op("illegal6",  3'd6, 9,                      9,                0,                      3,  1);

        // Result held in DONE while the consumer stalls; new requests ignored.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 10;
        bus.b        = 20;
        bus.operand  = 3'd0;
        @(posedge clk);
        #1;
        bus.a       = 99;
        bus.b       = 1;
        bus.operand = 3'd1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("hold_out_valid", 64'(bus.out_valid), 64'd1);
        check("hold_result", 64'(bus.result), 64'd30);
        check("hold_in_ready", 64'(bus.in_ready), 64'd0);
        check("hold_busy", 64'(bus.busy), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("hold_release", 64'({bus.out_valid, bus.in_ready}), 64'b01);

        // Reset in the middle of a division drops the pending result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 100;
        bus.b        = 7;
        bus.operand  = 3'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1;
        end
        check("abort_no_stale", 64'(seen), 64'd0);

        run_op("after_abort", 3'd0, 1, 1, 2, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
